// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
//
// Purpose:
//   Serialises 16-bit stereo sample pairs onto a Philips I2S link for a codec
//   DAC. A one-deep holding register accepts a {left, right} pair through a
//   valid/ready handshake. At the start of every frame (slot 0) that pair moves
//   into the frame register and is shifted out MSB first with the standard
//   one-bit I2S delay. When no new pair has arrived, the previous frame is
//   replayed and an underrun pulse is raised.
//
// Ports:
//   clock          in   system clock, all logic on its rising edge
//   reset          in   asynchronous active-high reset
//   enable         in   request the serial link to run
//   sample_left    in   [15:0] signed left sample
//   sample_right   in   [15:0] signed right sample
//   sample_valid   in   pair offered by the upstream filter
//   sample_ready   out  holding register empty (transfer on valid & ready)
//   bclk           out  codec bit clock
//   lrck           out  codec LR clock, low = left channel
//   dacdat         out  serial data
//   underrun       out  one-clock pulse when a frame load finds no data
//   underrun_count out  [15:0] saturating underrun count (optional, see below)
//
// Parameters:
//   BCLK_DIV       clock cycles per bclk half-period (default 6)
//
// Build option:
//   I2S_DAC_TX_UNDERRUN_CNT_EN  when defined, adds the underrun_count output.
// -----------------------------------------------------------------------------
module i2s_dac_tx #(
    parameter int BCLK_DIV = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrck,
    output logic        dacdat,
    output logic        underrun
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             bclk_reg, bclk_next;
    logic [4:0]       slot_reg, slot_next;
    logic             lrck_reg, lrck_next;
    logic             dacdat_reg, dacdat_next;
    logic [31:0]      frame_reg, frame_next;
    logic [31:0]      hold_reg, hold_next;
    logic             full_reg, full_next;
    logic             ready_reg, ready_next;
    logic             underrun_reg, underrun_next;

    logic             active;
    logic             tick;
    logic             fall;
    logic             frame_end;
    logic             stop;
    logic             start;
    logic             load;
    logic             xfer;
    logic [4:0]       slot_inc;
    logic [4:0]       bit_sel;

    // Event decode shared by the FSM and the datapath.
    always_comb begin
        active    = (state_reg != IDLE);
        tick      = active && (div_reg == DIV_MAX);
        fall      = tick && bclk_reg;
        frame_end = fall && (slot_reg == 5'd31);
        // Draining frame has finished slot 31 and nobody asked to continue.
        stop      = frame_end && (state_reg == DRAIN) && !enable;
        // Entering RUN begins a fresh slot 0, so it loads a frame as well.
        start     = (state_reg == IDLE) && enable;
        load      = start || (frame_end && !stop);
        xfer      = sample_valid && ready_reg;
        slot_inc  = slot_reg + 5'd1;
        // Slot k carries F[32-k]; for k = 0 this wraps to F[0] of the frame
        // still held in frame_reg, which gives the one-bit I2S delay for free.
        bit_sel   = 5'd0 - slot_inc;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (enable) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        div_next      = div_reg;
        bclk_next     = bclk_reg;
        slot_next     = slot_reg;
        lrck_next     = lrck_reg;
        dacdat_next   = dacdat_reg;
        frame_next    = frame_reg;
        hold_next     = hold_reg;
        full_next     = full_reg;
        underrun_next = 1'b0;

        if (!active) begin
            div_next    = '0;
            bclk_next   = 1'b0;
            slot_next   = 5'd0;
            lrck_next   = 1'b0;
            dacdat_next = 1'b0;
        end else begin
            div_next = tick ? '0 : div_reg + DIV_W'(1);
            if (tick) begin
                bclk_next = ~bclk_reg;
            end
            // lrck and data only move on bclk falling toggles.
            if (fall) begin
                slot_next   = slot_inc;
                lrck_next   = slot_inc[4];
                dacdat_next = frame_reg[bit_sel];
            end
        end

        // A load always sees the holding register as it was before this edge,
        // so a simultaneous transfer lands behind it rather than being skipped.
        if (load) begin
            if (full_reg) begin
                frame_next = hold_reg;
            end else begin
                underrun_next = 1'b1;
            end
        end

        // Returning to IDLE clears the frame so the next start replays zeros.
        if (stop) begin
            lrck_next   = 1'b0;
            dacdat_next = 1'b0;
            frame_next  = '0;
        end

        if (xfer) begin
            hold_next = {sample_left, sample_right};
            full_next = 1'b1;
        end else if (load) begin
            full_next = 1'b0;
        end

        ready_next = ~full_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            div_reg      <= '0;
            bclk_reg     <= 1'b0;
            slot_reg     <= 5'd0;
            lrck_reg     <= 1'b0;
            dacdat_reg   <= 1'b0;
            frame_reg    <= '0;
            hold_reg     <= '0;
            full_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            bclk_reg     <= bclk_next;
            slot_reg     <= slot_next;
            lrck_reg     <= lrck_next;
            dacdat_reg   <= dacdat_next;
            frame_reg    <= frame_next;
            hold_reg     <= hold_next;
            full_reg     <= full_next;
            ready_reg    <= ready_next;
            underrun_reg <= underrun_next;
        end
    end

`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] ucount_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ucount_reg <= 16'd0;
        end else if (underrun_next && (ucount_reg != 16'hFFFF)) begin
            ucount_reg <= ucount_reg + 16'd1;
        end
    end

    assign underrun_count = ucount_reg;
`endif

    assign sample_ready = ready_reg;
    assign bclk         = bclk_reg;
    assign lrck         = lrck_reg;
    assign dacdat       = dacdat_reg;
    assign underrun     = underrun_reg;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_dac_tx
//
// Directed bench for i2s_dac_tx with BCLK_DIV = 6 (12 clocks per slot,
// 384 clocks per frame). Serial frames are captured bit by bit at every bclk
// falling toggle and compared against hand-written sample words.
// With I2S_DAC_TX_UNDERRUN_CNT_EN defined the underrun counter is also checked.
// -----------------------------------------------------------------------------
module tb_i2s_dac_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        bclk;
    logic        lrck;
    logic        dacdat;
    logic        underrun;
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    i2s_dac_tx #(.BCLK_DIV(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrck         (lrck),
        .dacdat       (dacdat),
        .underrun     (underrun)
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle counter and edge monitor, sampled on the falling clock edge.
    int   cyc     = 0;
    int   rise1   = -1;
    int   rise2   = -1;
    int   lr_rise = -1;
    int   lr_fall = -1;
    int   un_hi   = 0;
    int   un_rise = 0;
    int   rdy_hi  = 0;
    int   xfer_n  = 0;
    logic bclk_q  = 1'b0;
    logic lrck_q  = 1'b0;
    logic un_q    = 1'b0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bclk === 1'b1 && bclk_q === 1'b0) begin
            if (rise1 < 0) rise1 = cyc;
            else if (rise2 < 0) rise2 = cyc;
        end
        if (lrck === 1'b1 && lrck_q === 1'b0 && lr_rise < 0) lr_rise = cyc;
        if (lrck === 1'b0 && lrck_q === 1'b1 && lr_rise >= 0 && lr_fall < 0) lr_fall = cyc;
        if (underrun === 1'b1) un_hi++;
        if (underrun === 1'b1 && un_q === 1'b0) un_rise++;
        if (sample_ready === 1'b1) rdy_hi++;
        if (sample_ready === 1'b1 && sample_valid === 1'b1) xfer_n++;
        bclk_q = bclk;
        lrck_q = lrck;
        un_q   = underrun;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the next bclk falling toggle; returns #1 after it.
    task automatic wait_fall();
        logic prev;
        bit   seen;
        prev = bclk;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (prev === 1'b1 && bclk === 1'b0) seen = 1'b1;
            prev = bclk;
        end
        if (!seen) check("bclk_fall_timeout", 32'(seen), 32'd1);
    endtask

    // Capture slots 1..31 of the current frame plus slot 0 of the next one,
    // which reassembles the frame word F. Optionally drops/raises enable
    // right after the given slot begins.
    task automatic capture_frame(input int drop_slot, input int raise_slot,
                                 output logic [31:0] w);
        w = '0;
        for (int s = 1; s <= 32; s++) begin
            wait_fall();
            w[32-s] = dacdat;
            if (s == drop_slot)  enable = 1'b0;
            if (s == raise_slot) enable = 1'b1;
        end
    endtask

    task automatic send_pair(input logic [31:0] p);
        sample_left  = p[31:16];
        sample_right = p[15:0];
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    logic [31:0] feed [4];

    // Holds sample_valid high and offers the next pair after each transfer.
    task automatic feed_pairs();
        bit got;
        for (int i = 0; i < 4; i++) begin
            sample_left  = feed[i][31:16];
            sample_right = feed[i][15:0];
            sample_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 900 && !got; t++) begin
                @(negedge clock);
                got = sample_ready;
                @(posedge clock);
                #1;
            end
            if (!got) check("feed_timeout", 32'(got), 32'd1);
            $display("xfer pair %0d = %h", i, feed[i]);
        end
        sample_valid = 1'b0;
    endtask

    localparam logic [31:0] PAIR_A = 32'h8001_7FFE;
    localparam logic [31:0] PAIR_B = 32'hC003_0005;
    localparam logic [31:0] PAIR_D = 32'h0001_8000;
    localparam logic [31:0] PAIR_E = 32'h7FFF_0001;
    localparam logic [31:0] PAIR_G = 32'hFFFF_FFFF;
    localparam logic [31:0] PAIR_H = 32'h1111_2222;

    logic [31:0] w;
    logic [31:0] wf;
    logic [31:0] exp_seq [4];
    int          t0, t2, t3, r0, x0, u0, idle_hi;

    initial begin
        feed[0] = 32'h1234_5678;
        feed[1] = 32'h9ABC_DEF0;
        feed[2] = 32'h0F0F_F0F0;
        feed[3] = 32'hA5A5_5A5A;
        exp_seq[0] = PAIR_B;
        exp_seq[1] = feed[0];
        exp_seq[2] = feed[1];
        exp_seq[3] = feed[2];

        reset        = 1'b1;
        enable       = 1'b0;
        sample_left  = 16'h0;
        sample_right = 16'h0;
        sample_valid = 1'b0;

        // Reset values.
        repeat (3) tick();
        check("rst_bclk",     32'(bclk),         32'd0);
        check("rst_lrck",     32'(lrck),         32'd0);
        check("rst_dacdat",   32'(dacdat),       32'd0);
        check("rst_underrun", 32'(underrun),     32'd0);
        check("rst_ready",    32'(sample_ready), 32'd1);
        reset = 1'b0;
        tick();
        check("idle_ready", 32'(sample_ready), 32'd1);

        // Transfer A in IDLE, then start.
        send_pair(PAIR_A);
        $display("xfer A = %h", PAIR_A);
        check("ready_after_xfer", 32'(sample_ready), 32'd0);
        enable = 1'b1;
        tick();
        t0 = cyc;
        check("ready_after_load", 32'(sample_ready), 32'd1);
        check("start_underrun",   32'(underrun),     32'd0);
        check("start_slot0_dat",  32'(dacdat),       32'd0);

        // Frame 1: A, slots 1..16 = 0x8001, 17..31 = 0x7FFE>>1, next slot 0 = 0.
        capture_frame(0, 0, w);
        $display("frame 1 word = %h", w);
        check("f1_left_bits",  32'(w[31:16]), 32'h8001);
        check("f1_right_15",   32'(w[15:1]),  32'h3FFF);
        check("f1_next_slot0", 32'(w[0]),     32'd0);

        // Frames 2..4 replay A with underruns; B arrives during frame 4.
        capture_frame(0, 0, w);
        $display("frame 2 word = %h", w);
        check("f2_repeat", w, PAIR_A);
        check("bclk_first_rise", 32'(rise1 - t0),   32'd6);
        check("bclk_period",     32'(rise2 - rise1), 32'd12);
        check("lrck_low_len",    32'(lr_rise - t0), 32'd192);
        check("lrck_high_len",   32'(lr_fall - lr_rise), 32'd192);
        capture_frame(0, 0, w);
        $display("frame 3 word = %h", w);
        check("f3_repeat", w, PAIR_A);
        send_pair(PAIR_B);
        $display("xfer B = %h", PAIR_B);
        check("ready_b_held", 32'(sample_ready), 32'd0);
        capture_frame(0, 0, w);
        $display("frame 4 word = %h", w);
        check("f4_repeat", w, PAIR_A);
        check("underrun_pulses", 32'(un_rise), 32'd3);
        check("underrun_cycles", 32'(un_hi),   32'd3);
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
        check("underrun_count", 32'(underrun_count), 32'd3);
`endif

        // Continuous sample_valid: one transfer per frame, nothing dropped.
        r0 = rdy_hi;
        x0 = xfer_n;
        u0 = un_rise;
        fork
            feed_pairs();
            begin
                for (int f = 0; f < 4; f++) begin
                    capture_frame(0, 0, wf);
                    $display("stream frame %0d word = %h", f, wf);
                    check("stream_frame", wf, exp_seq[f]);
                end
            end
        join
        check("stream_ready_cycles", 32'(rdy_hi - r0), 32'd4);
        check("stream_transfers",    32'(xfer_n - x0), 32'd4);
        check("stream_no_underrun",  32'(un_rise - u0), 32'd0);

        // Drop enable at slot 5: frame finishes through slot 31, then IDLE.
        t3 = cyc;
        capture_frame(5, 0, w);
        $display("drain frame word = %h", w);
        check("drain_frame_bits", 32'(w[31:1]), 32'(feed[3][31:1]));
        check("drain_frame_len",  32'(cyc - t3), 32'd384);
        check("idle_bclk",   32'(bclk),         32'd0);
        check("idle_lrck",   32'(lrck),         32'd0);
        check("idle_dacdat", 32'(dacdat),       32'd0);
        check("idle_ready",  32'(sample_ready), 32'd1);
        idle_hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bclk !== 1'b0 || lrck !== 1'b0 || dacdat !== 1'b0) idle_hi++;
        end
        check("idle_quiet", 32'(idle_hi), 32'd0);

        // Restart; drop at slot 5 and re-raise at slot 20 of DRAIN: no gap.
        send_pair(PAIR_D);
        $display("xfer D = %h", PAIR_D);
        enable = 1'b1;
        tick();
        t2 = cyc;
        u0 = un_rise;
        send_pair(PAIR_E);
        $display("xfer E = %h", PAIR_E);
        capture_frame(5, 20, w);
        $display("rerun frame 1 word = %h", w);
        check("rerun_frame_d", w, PAIR_D);
        send_pair(PAIR_G);
        $display("xfer G = %h", PAIR_G);
        capture_frame(0, 0, w);
        $display("rerun frame 2 word = %h", w);
        check("rerun_frame_e", w, PAIR_E);
        check("rerun_no_gap", 32'(cyc - t2), 32'd768);
        check("rerun_no_underrun", 32'(un_rise - u0), 32'd0);

        // Reset pulsed at slot 12 while H is held.
        send_pair(PAIR_H);
        $display("xfer H = %h", PAIR_H);
        check("h_held", 32'(sample_ready), 32'd0);
        for (int i = 0; i < 12; i++) wait_fall();
        repeat (7) tick();
        check("pre_reset_bclk",   32'(bclk),   32'd1);
        check("pre_reset_dacdat", 32'(dacdat), 32'd1);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check("async_rst_bclk",     32'(bclk),         32'd0);
        check("async_rst_lrck",     32'(lrck),         32'd0);
        check("async_rst_dacdat",   32'(dacdat),       32'd0);
        check("async_rst_underrun", 32'(underrun),     32'd0);
        check("async_rst_ready",    32'(sample_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        // H was discarded, so the first load finds nothing and replays zeros.
        check("restart_underrun", 32'(underrun),     32'd1);
        check("restart_ready",    32'(sample_ready), 32'd1);
`ifdef I2S_DAC_TX_UNDERRUN_CNT_EN
        check("restart_count", 32'(underrun_count), 32'd1);
`endif
        tick();
        check("restart_underrun_width", 32'(underrun), 32'd0);
        repeat (4) tick();
        check("restart_bclk_low",  32'(bclk), 32'd0);
        tick();
        check("restart_bclk_rise", 32'(bclk), 32'd1);
        capture_frame(0, 0, w);
        $display("post-reset frame word = %h", w);
        check("post_reset_frame", w, 32'h0);
        enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_dac_tx.md
I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 The block SHALL have parameter BCLK_DIV, default 6, meaning clock cycles per BCLK half-period (18.432 MHz / 12 = 1.536 MHz = 48 kHz x 32).
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: requests serial output to run.
REQ-005 The block SHALL have port sample_left, input, 16 bits: signed left sample from the upstream filter.
REQ-006 The block SHALL have port sample_right, input, 16 bits: signed right sample.
REQ-007 The block SHALL have port sample_valid, input, 1 bit: the sample pair is offered.
REQ-008 The block SHALL have port sample_ready, output, 1 bit: the holding register is empty.
REQ-009 The block SHALL have port bclk, output, 1 bit: codec bit clock.
REQ-010 The block SHALL have port lrck, output, 1 bit: codec DAC LR clock; low means left.
REQ-011 The block SHALL have port dacdat, output, 1 bit: serial data.
REQ-012 The block SHALL have port underrun, output, 1 bit: one-clock pulse at a frame load with no data.

Function
REQ-013 A transfer SHALL occur on a clock edge where sample_valid and sample_ready are both 1; {sample_left, sample_right} is then latched into the holding register and sample_ready goes 0 on the next cycle.
REQ-014 The FSM SHALL have states IDLE, RUN and DRAIN, with these transitions: IDLE to RUN when enable is 1; RUN to DRAIN when enable is 0; DRAIN to IDLE after slot 31 completes; DRAIN back to RUN if enable returns to 1 before slot 31 completes.
REQ-015 In IDLE, bclk, lrck and dacdat SHALL be held at 0 and the divider and slot counter SHALL be held at 0; the handshake SHALL stay active.
REQ-016 In RUN and DRAIN, bclk SHALL toggle every BCLK_DIV clocks, starting with a rising toggle BCLK_DIV clocks after entering RUN.
REQ-017 A 5-bit slot counter k SHALL advance on each bclk falling toggle and wrap from 31 to 0.
REQ-018 lrck SHALL be 0 for k = 0..15 and 1 for k = 16..31; lrck and dacdat SHALL change only at bclk falling toggles.
REQ-019 The frame word F SHALL be {left, right}, 32 bits; I2S one-bit delay SHALL apply: at slot k = 1..31, dacdat = F[32-k], and at slot 0, dacdat = F[0] of the previous frame.
REQ-020 At the slot-0 falling toggle, the holding register SHALL move into the shift register and the holding register SHALL become empty (sample_ready = 1 on the next cycle).
REQ-021 If the holding register is empty at the slot-0 load, the previous F SHALL be repeated and underrun SHALL pulse for one clock.
REQ-022 If a transfer and a slot-0 load occur on the same edge while the holding register is full, the load SHALL take the old contents and the new pair SHALL be written to the holding register, which stays full.
REQ-023 On the first frame after IDLE, the "previous F" SHALL be 0.
REQ-024 All outputs SHALL be registered; the latency from a transfer to MSB-on-dacdat SHALL be at most 2 frames.

Reset
REQ-025 While reset is high, the outputs SHALL be: bclk = 0, lrck = 0, dacdat = 0, underrun = 0, sample_ready = 1; the state SHALL be IDLE, the holding register and shift register 0, and all counters 0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately, with no frame completion; after release, operation SHALL restart per REQ-014 and REQ-016.

Configuration
REQ-027 With macro I2S_DAC_TX_UNDERRUN_CNT_EN defined, the block SHALL add output underrun_count (16 bits): a saturating count at 0xFFFF of underrun pulses, cleared by reset.
REQ-028 Without I2S_DAC_TX_UNDERRUN_CNT_EN, the port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Test: reset, then enable = 1 with BCLK_DIV = 6 -> first bclk rise 6 clocks after RUN; bclk period 12 clocks; lrck period 384 clocks with 192 low.
REQ-030 Test: transfer L = 0x8001, R = 0x7FFE before a slot-0 load -> next frame dacdat at slots 1..16 = 1000000000000001, slots 17..31 = first 15 bits of 0x7FFE, next slot 0 = 0.
REQ-031 Test: no transfer for 3 frames after one pair -> that pair repeats; underrun pulses 3 times, each 1 clock wide; underrun_count = 3 when the macro is defined.
REQ-032 Test: sample_valid held at 1 continuously -> exactly one transfer per frame (sample_ready high for 1 clock after each load); no pair dropped; no underrun.
REQ-033 Test: enable dropped at slot 5 -> the frame finishes through slot 31, then IDLE with all outputs 0; enable re-raised at slot 20 of DRAIN -> continues in RUN without a gap.
REQ-034 Test: reset pulsed at slot 12 -> all outputs 0 within the same cycle; sample_ready = 1; the held pair is discarded.
